md_unit: RTL and testbench
==========================

Name: md_unit

Overview:
- Multiply/divide unit for the E stage of the 5-stage MIPS pipeline.
- Operands come from the E-stage forwarded register values: rs after forwarding on `a`, rt after forwarding on `b`.
- Executes mult/multu/div/divu over a fixed number of cycles and holds the HI/LO architectural registers. mthi/mtlo write them directly.
- `busy` goes to the hazard unit, which stalls D-stage md/mfhi/mflo instructions. `hi`/`lo` feed the E-stage result mux for mfhi/mflo.

Parameters:
- MULT_CYCLES, 5: cycles `busy` stays high for mult/multu. Must be ≥1.
- DIV_CYCLES, 10: cycles `busy` stays high for div/divu. Must be ≥1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  E-stage instruction is an md op; qualifies md_op.
- md_op  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
- a  input  32  rs operand (forwarded).
- b  input  32  rt operand (forwarded).
- busy  output  1  multi-cycle operation in progress (registered).
- hi  output  32  HI register (registered).
- lo  output  32  LO register (registered).

Behaviour:
- Reset (asynchronous, any time): busy=0, hi=0, lo=0, cycle counter=0, operand/result latches=0. An in-flight operation is discarded; no later write to HI/LO occurs.
- States: IDLE (busy=0), RUN (busy=1).
- IDLE, start=1, md_op 1-4, sampled at edge k:
  - Latch the operation's result into an internal pending register (hi_p, lo_p). The result is computed from a/b as sampled at edge k.
  - Load counter with N-1, where N=MULT_CYCLES or DIV_CYCLES. Set busy=1.
- RUN: each edge, counter decrements. At the edge where counter==0: hi<=hi_p, lo<=lo_p, busy<=0, go to IDLE.
  - Net timing: busy is high exactly N cycles, edges k+1 through k+N.
  - New hi/lo are visible immediately after edge k+N, coincident with busy falling.
- IDLE, start=1, md_op 5: hi<=a at that edge; lo unchanged; busy stays 0.
- IDLE, start=1, md_op 6: lo<=a; hi unchanged; busy stays 0.
- md_op 0 or 7, or start=0: no state change.
- start=1 while busy=1 (any md_op):
  - Ignored. The hazard unit guarantees this never happens; the block still must not corrupt state.
  - The pending result and counter are unaffected.
- hi/lo hold their old values for the whole RUN period. mfhi/mflo are blocked by the stall, not by this block.
- Arithmetic:
  - mult: 64-bit signed product of a and b; hi=[63:32], lo=[31:0].
  - multu: same, unsigned.
  - div: signed. lo=quotient truncated toward zero; hi=remainder with the sign of the dividend (a).
  - div with a=0x80000000, b=0xFFFFFFFF: lo=0x80000000, hi=0.
  - divu: unsigned quotient/remainder.
  - Divide by zero (div or divu): lo=0xFFFFFFFF, hi=a. Still takes DIV_CYCLES.
- Result datapath: implementation free (combinational at capture or iterative), provided the register-level timing above is exact.

Test Plan:
- mult a=0xFFFFFFFD(-3) b=5, start one cycle -> busy=1 for exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFF1; hi/lo unchanged while busy.
- multu a=0xFFFFFFFF b=2 -> after 5 cycles hi=0x00000001, lo=0xFFFFFFFE. Then div a=0xFFFFFFF9(-7) b=2 -> busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- divu a=7 b=2 -> lo=3, hi=1. Then div a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0. Then divu a=0x1234 b=0 -> lo=0xFFFFFFFF, hi=0x1234.
- Idle mthi a=0xAAAA0000 -> hi=0xAAAA0000 after one edge, busy never rises. Next cycle mtlo a=0x5555 -> lo=0x5555, hi unchanged.
- During a mult (busy=1): start with md_op=5 a=0xDEADBEEF, then with md_op=3 -> both ignored; final hi/lo equal the mult result; busy still drops after exactly 5 cycles.
- Start div, assert reset asynchronously mid-cycle at busy cycle 4 -> busy, hi, lo go to 0 immediately without a clock edge. After release, no late HI/LO write occurs over 20 further cycles.

Source files
------------

// File: rtl/md_unit.sv
// Multiply/divide unit for the E stage: owns HI/LO, runs mult/div ops for a fixed
// cycle count while busy is high, and writes HI/LO directly for mthi/mtlo.
module md_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic [0:0] {StIdle, StRun} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hi_q, hi_d, lo_q, lo_d;
    logic [31:0]      hi_p_q, hi_p_d, lo_p_q, lo_p_d;

    logic [63:0] prod_s, prod_u;
    logic [31:0] a_mag, b_mag, b_div, q_mag, r_mag, q_s, r_s, q_u, r_u;
    logic        b_zero;

    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u = {32'd0, a} * {32'd0, b};

    // Signed divide via magnitudes; 0x80000000 is its own magnitude, which makes
    // the 0x80000000 / -1 overflow case fall out as quotient 0x80000000, remainder 0.
    assign b_zero = (b == 32'd0);
    assign a_mag  = a[31] ? -a : a;
    assign b_mag  = b[31] ? -b : b;
    assign b_div  = b_zero ? 32'd1 : b_mag;
    assign q_mag  = a_mag / b_div;
    assign r_mag  = a_mag % b_div;
    assign q_s    = (a[31] ^ b[31]) ? -q_mag : q_mag;
    assign r_s    = a[31] ? -r_mag : r_mag;
    assign q_u    = a / (b_zero ? 32'd1 : b);
    assign r_u    = a % (b_zero ? 32'd1 : b);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        hi_p_d  = hi_p_q;
        lo_p_d  = lo_p_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    case (md_op)
                        OP_MULT: begin
                            {hi_p_d, lo_p_d} = prod_s;
                            cnt_d            = MULT_LOAD;
                            state_d          = StRun;
                        end
                        OP_MULTU: begin
                            {hi_p_d, lo_p_d} = prod_u;
                            cnt_d            = MULT_LOAD;
                            state_d          = StRun;
                        end
                        OP_DIV: begin
                            hi_p_d  = b_zero ? a : r_s;
                            lo_p_d  = b_zero ? 32'hFFFF_FFFF : q_s;
                            cnt_d   = DIV_LOAD;
                            state_d = StRun;
                        end
                        OP_DIVU: begin
                            hi_p_d  = b_zero ? a : r_u;
                            lo_p_d  = b_zero ? 32'hFFFF_FFFF : q_u;
                            cnt_d   = DIV_LOAD;
                            state_d = StRun;
                        end
                        OP_MTHI: hi_d = a;
                        OP_MTLO: lo_d = a;
                        default: ;
                    endcase
                end
            end
            StRun: begin
                // New starts are ignored here; the hazard unit should never issue them.
                if (cnt_q == '0) begin
                    hi_d    = hi_p_q;
                    lo_d    = lo_p_q;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            hi_p_q  <= '0;
            lo_p_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            hi_p_q  <= hi_p_d;
            lo_p_q  <= lo_p_d;
        end
    end

    assign busy = (state_q == StRun);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: table of directed operations plus hand-written
// sequences for starts during busy and asynchronous reset mid-operation.
module tb_md_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp;
    int n_err;

    md_unit #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .md_op(md_op),
        .a    (a),
        .b    (b),
        .busy (busy),
        .hi   (hi),
        .lo   (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

    // Issue one op for a single cycle, count busy cycles, verify HI/LO hold during RUN.
    task automatic run_vec(input vec_t v);
        logic [31:0] prev_hi;
        logic [31:0] prev_lo;
        int          cnt;
        logic        held;
        @(negedge clk);
        prev_hi = hi;
        prev_lo = lo;
        start   = 1'b1;
        md_op   = v.op;
        a       = v.a;
        b       = v.b;
        @(negedge clk);
        start = 1'b0;
        md_op = 3'd0;
        cnt   = 0;
        held  = 1'b1;
        while (busy === 1'b1 && cnt < 100) begin
            if (hi !== prev_hi || lo !== prev_lo) held = 1'b0;
            cnt++;
            @(negedge clk);
        end
        check({v.name, " busy_cycles"}, 32'(cnt), 32'(v.cyc));
        check({v.name, " hold"}, {31'd0, held}, 32'd1);
        check({v.name, " hi"}, hi, v.hi);
        check({v.name, " lo"}, lo, v.lo);
    endtask

    initial begin
        int   cnt;
        logic ok;

        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        start = 1'b0;
        md_op = 3'd0;
        a     = '0;
        b     = '0;

        vecs[0]  = '{"mult_neg",   3'd1, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 5};
        vecs[1]  = '{"multu",      3'd2, 32'hFFFF_FFFF, 32'd2,         32'h0000_0001, 32'hFFFF_FFFE, 5};
        vecs[2]  = '{"div_neg",    3'd3, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
        vecs[3]  = '{"divu",       3'd4, 32'd7,         32'd2,         32'd1,         32'd3,         10};
        vecs[4]  = '{"div_ovf",    3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 10};
        vecs[5]  = '{"divu_zero",  3'd4, 32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF, 10};
        vecs[6]  = '{"div_zero",   3'd3, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 10};
        vecs[7]  = '{"mult_negb",  3'd1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFF2, 5};
        vecs[8]  = '{"multu_big",  3'd2, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 5};
        vecs[9]  = '{"div_negdiv", 3'd3, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 10};
        vecs[10] = '{"mthi",       3'd5, 32'hAAAA_0000, 32'd0,         32'hAAAA_0000, 32'hFFFF_FFFD, 0};
        vecs[11] = '{"mtlo",       3'd6, 32'h0000_5555, 32'd0,         32'hAAAA_0000, 32'h0000_5555, 0};
        vecs[12] = '{"op_none",    3'd0, 32'h1234_5678, 32'd9,         32'hAAAA_0000, 32'h0000_5555, 0};
        vecs[13] = '{"op_resv",    3'd7, 32'h1234_5678, 32'd9,         32'hAAAA_0000, 32'h0000_5555, 0};
        vecs[14] = '{"divu_big",   3'd4, 32'hFFFF_FFFF, 32'd16,        32'h0000_000F, 32'h0FFF_FFFF, 10};

        #12;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset hi", hi, 32'd0);
        check("reset lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 15; i++) run_vec(vecs[i]);

        // Starts issued while busy must be ignored: mult 3*4 with mthi and div thrown at it.
        @(negedge clk);
        start = 1'b1;
        md_op = 3'd1;
        a     = 32'd3;
        b     = 32'd4;
        @(negedge clk);
        cnt   = (busy === 1'b1) ? 1 : 0;
        md_op = 3'd5;
        a     = 32'hDEAD_BEEF;
        @(negedge clk);
        if (busy === 1'b1) cnt++;
        md_op = 3'd3;
        a     = 32'd100;
        b     = 32'd7;
        @(negedge clk);
        if (busy === 1'b1) cnt++;
        start = 1'b0;
        md_op = 3'd0;
        @(negedge clk);
        while (busy === 1'b1 && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        check("ignore busy_cycles", 32'(cnt), 32'd5);
        check("ignore hi", hi, 32'd0);
        check("ignore lo", lo, 32'd12);
        @(negedge clk);
        check("ignore no_restart", {31'd0, busy}, 32'd0);

        // Asynchronous reset during the 4th busy cycle of a div.
        @(negedge clk);
        start = 1'b1;
        md_op = 3'd5;
        a     = 32'h1111_1111;
        @(negedge clk);
        md_op = 3'd3;
        a     = 32'd100;
        b     = 32'd7;
        @(negedge clk);
        start = 1'b0;
        md_op = 3'd0;
        check("pre_reset hi", hi, 32'h1111_1111);
        check("pre_reset busy", {31'd0, busy}, 32'd1);
        repeat (3) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("async busy", {31'd0, busy}, 32'd0);
        check("async hi", hi, 32'd0);
        check("async lo", lo, 32'd0);
        @(negedge clk);
        #1;
        reset = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) ok = 1'b0;
        end
        check("post_reset quiet", {31'd0, ok}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
